// File: rtl/mem_loader_if.sv
// Host byte stream and memory write/read port bundle for mem_loader.
// master = loader view, slave = host/memory view.
interface mem_loader_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_clken;
  logic          mem_write;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_value;

  modport master (
    input  in_valid, in_data, mem_value,
    output in_ready, mem_clken, mem_write, mem_adr, mem_data
  );

  modport slave (
    output in_valid, in_data, mem_value,
    input  in_ready, mem_clken, mem_write, mem_adr, mem_data
  );
endinterface

// File: rtl/mem_loader.sv
// Streams a program image into the SAP memory at addresses 0..DEPTH-1 while holding the CPU.
// Optional readback checksum verify pass enabled by defining SAP_LOADER_VERIFY_EN.
module mem_loader #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         start,
  mem_loader_if.master bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         verify_err
);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef SAP_LOADER_VERIFY_EN
  localparam int unsigned VW = AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] sum;
  logic          accept;

`ifdef SAP_LOADER_VERIFY_EN
  logic [VW-1:0] vcnt;
  logic [DW-1:0] rsum;
  logic          verr;
  assign verify_err = verr;
`else
  logic unused_mem_value;
  assign unused_mem_value = ^bus.mem_value;
  assign verify_err       = 1'b0;
`endif

  assign bus.in_ready = (state == LOAD);
  assign accept       = bus.in_valid && (state == LOAD);

  // Sequencer: state plus all registered outputs
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      sum           <= '0;
      bus.mem_clken <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_adr   <= '0;
      bus.mem_data  <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
`ifdef SAP_LOADER_VERIFY_EN
      vcnt          <= '0;
      rsum          <= '0;
      verr          <= 1'b0;
`endif
    end else begin
      bus.mem_clken <= 1'b0;
      bus.mem_write <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= '0;
            sum      <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
`ifdef SAP_LOADER_VERIFY_EN
            verr     <= 1'b0;
`endif
          end else if (state == DONE) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            bus.mem_clken <= 1'b1;
            bus.mem_write <= 1'b1;
            bus.mem_adr   <= ptr;
            bus.mem_data  <= bus.in_data;
            ptr           <= ptr + AW'(1);
            sum           <= DW'(sum + bus.in_data);
            if (ptr == LAST) begin
`ifdef SAP_LOADER_VERIFY_EN
              state <= VERIFY;
              vcnt  <= '0;
              rsum  <= '0;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef SAP_LOADER_VERIFY_EN
        // Read address k issued at vcnt=k; its data is summed at vcnt=k+2
        VERIFY: begin
          vcnt <= vcnt + VW'(1);
          if (vcnt < VW'(DEPTH)) begin
            bus.mem_clken <= 1'b1;
            bus.mem_adr   <= vcnt[AW-1:0];
          end
          if (vcnt >= VW'(2)) begin
            rsum <= DW'(rsum + bus.mem_value);
          end
          if (vcnt == VW'(DEPTH + 1)) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            verr     <= (DW'(rsum + bus.mem_value) != sum);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader with a registered-read memory model.
module tb_mem_loader;
  logic sysclk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, done, verify_err;
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       flip;
  int n_chk  = 0;
  int n_fail = 0;

  mem_loader_if #(.AW(4), .DW(8)) bus ();

  mem_loader #(.AW(4), .DW(8)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .verify_err (verify_err)
  );

  always #5 sysclk = ~sysclk;

  // Memory model: registered read, write on clken&write, optional corruption of word 3 on read
  always @(posedge sysclk) begin
    if (bus.mem_clken) begin
      if (bus.mem_write) mem[bus.mem_adr] <= bus.mem_data;
      if (flip && bus.mem_adr == 4'd3) bus.mem_value <= 8'hE1;
      else                             bus.mem_value <= mem[bus.mem_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clken"}, 32'(bus.mem_clken), 32'd0);
    chk({tag, "_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_adr"},   32'(bus.mem_adr),   32'd0);
    chk({tag, "_data"},  32'(bus.mem_data),  32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),      32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
    chk({tag, "_verr"},  32'(verify_err),    32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    chk("start_hold",  32'(cpu_hold),     32'd1);
    chk("start_done",  32'(done),         32'd0);
    chk("start_ready", 32'(bus.in_ready), 32'd1);
    chk("start_verr",  32'(verify_err),   32'd0);
  endtask

  // Streams img[0..n-1]; optional valid gap after byte gap_after; start raised with bytes s1/s2
  task automatic stream(input int n, input int gap_after, input int gap_len,
                        input int s1, input int s2);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = img[i];
      start        = (i == s1) || (i == s2);
      @(negedge sysclk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
      chk("wr",    32'(bus.mem_write), 32'd1);
      chk("clken", 32'(bus.mem_clken), 32'd1);
      chk("adr",   32'(bus.mem_adr),   i);
      chk("data",  32'(bus.mem_data),  32'(img[i]));
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge sysclk);
          chk("gap_wr",    32'(bus.mem_write), 32'd0);
          chk("gap_clken", 32'(bus.mem_clken), 32'd0);
          chk("gap_adr",   32'(bus.mem_adr),   i);
          chk("gap_ready", 32'(bus.in_ready),  32'd1);
        end
      end
    end
  endtask

  // Called at the negedge right after the final accept edge
  task automatic finish_check(input logic exp_err);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_done",  32'(done),         32'd0);
    chk("full_hold",  32'(cpu_hold),     32'd1);
`ifdef SAP_LOADER_VERIFY_EN
    for (int k = 0; k < 18; k++) begin
      @(negedge sysclk);
      if (k < 16) begin
        chk("vfy_adr",   32'(bus.mem_adr),   k);
        chk("vfy_clken", 32'(bus.mem_clken), 32'd1);
        chk("vfy_write", 32'(bus.mem_write), 32'd0);
      end
      if (k < 17) begin
        chk("vfy_done", 32'(done),     32'd0);
        chk("vfy_hold", 32'(cpu_hold), 32'd1);
      end
    end
    chk("end_verr", 32'(verify_err), 32'(exp_err));
`else
    @(negedge sysclk);
    chk("end_verr", 32'(verify_err), 32'd0);
`endif
    chk("end_done",  32'(done),          32'd1);
    chk("end_hold",  32'(cpu_hold),      32'd0);
    chk("end_write", 32'(bus.mem_write), 32'd0);
  endtask

  task automatic chk_mem();
    for (int k = 0; k < 16; k++) chk("mem", 32'(mem[k]), 32'(img[k]));
  endtask

  initial begin
    logic [7:0] img1 [16];
    img1 = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h14, 8'h05, 8'h06,
             8'h07, 8'h0F, 8'h0E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    img          = img1;
    flip         = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #2;
    chk_all_zero("rst");
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk_all_zero("idle");

    // 1: back-to-back image
    pulse_start();
    stream(16, -1, 0, -1, -1);
    finish_check(1'b0);
    chk_mem();

`ifdef SAP_LOADER_VERIFY_EN
    // 5: corrupted readback of word 3
    flip = 1'b1;
    pulse_start();
    stream(16, -1, 0, -1, -1);
    finish_check(1'b1);
    flip = 1'b0;
`endif

    // 2: three-cycle valid gap after byte 5
    pulse_start();
    stream(16, 5, 3, -1, -1);
    finish_check(1'b0);

    // 3: start at byte 8 and with the final accept are ignored
    pulse_start();
    stream(16, -1, 0, 8, 15);
    finish_check(1'b0);
    @(negedge sysclk);
    chk("noreload_ready", 32'(bus.in_ready), 32'd0);
    chk("noreload_done",  32'(done),         32'd1);

    // 4: reset after byte 7, then a full reload from address 0
    pulse_start();
    stream(8, -1, 0, -1, -1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("postrst_done", 32'(done),         32'd0);
    chk("postrst_hold", 32'(cpu_hold),     32'd0);
    chk("postrst_ready", 32'(bus.in_ready), 32'd0);
    pulse_start();
    stream(16, -1, 0, -1, -1);
    finish_check(1'b0);
    chk_mem();

    // 6: restart from DONE with a different image
    for (int k = 0; k < 16; k++) img[k] = 8'hA0 + 8'(k);
    pulse_start();
    stream(16, -1, 0, -1, -1);
    finish_check(1'b0);
    chk_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
